// File: rtl/chirp_seq_ctrl_if.sv
// Chirp DDS word bus: 4-phase REQ/ACK crossing plus held DDS words.
// master drives REQ/DDS_*, slave (DDS stage side) drives ACK.
interface chirp_seq_ctrl_if;
   logic        REQ;
   logic        ACK;
   logic [47:0] DDS_freq;
   logic [47:0] DDS_delta_freq;
   logic [31:0] DDS_delta_rate;

   modport master (
      output REQ,
      output DDS_freq,
      output DDS_delta_freq,
      output DDS_delta_rate,
      input  ACK
   );

   modport slave (
      input  REQ,
      input  DDS_freq,
      input  DDS_delta_freq,
      input  DDS_delta_rate,
      output ACK
   );
endinterface

// File: rtl/chirp_seq_ctrl.sv
// Chirp sequencer (clk_48): captures a chirp config, pushes the DDS words
// to the 96 MHz stage over a 4-phase REQ/ACK bus and drives the start gate.
// Ports: clk_48/rst (sync, active high); cfg_* + cfg_wr config capture;
//   arm/abort burst control; dds bus (REQ/ACK/DDS_*); start, busy,
//   cfg_valid, cfg_err, pulse_cnt, tmo_err status.
// Option: define CHIRP_SEQ_TIMEOUT_EN for the ACK watchdog (TMO_CYC).
module chirp_seq_ctrl #(
   parameter int CNT_W   = 32,
   parameter int NP_W    = 16,
   parameter int TMO_CYC = 1024
) (
   input  logic             clk_48,
   input  logic             rst,
   input  logic             cfg_wr,
   input  logic [47:0]      cfg_freq,
   input  logic [47:0]      cfg_delta_freq,
   input  logic [31:0]      cfg_delta_rate,
   input  logic [CNT_W-1:0] cfg_pulse_len,
   input  logic [CNT_W-1:0] cfg_period,
   input  logic [NP_W-1:0]  cfg_num_pulses,
   input  logic             arm,
   input  logic             abort,
   chirp_seq_ctrl_if.master dds,
   output logic             start,
   output logic             busy,
   output logic             cfg_valid,
   output logic             cfg_err,
   output logic [NP_W-1:0]  pulse_cnt,
   output logic             tmo_err
);

   typedef enum logic [2:0] {
      IDLE,
      XFER_REQ,
      XFER_REL,
      READY,
      PULSE,
      GAP
   } state_t;

   localparam logic [CNT_W:0] ONE = (CNT_W+1)'(1);
   localparam logic [CNT_W:0] TWO = (CNT_W+1)'(2);

   state_t state, state_nx;

   logic [47:0]      sh_freq, sh_dfreq;
   logic [31:0]      sh_rate;
   logic [CNT_W-1:0] sh_len, sh_period;
   logic [NP_W-1:0]  sh_np;
   logic             pending;

   logic [47:0]      dds_freq_q, dds_dfreq_q;
   logic [31:0]      dds_rate_q;

   // cycles since the current pulse rose
   logic [CNT_W:0]   ph_cnt;
   logic [CNT_W:0]   len_x, per_x, eff_period;

   logic idle_rdy, xfer_st;
   logic cfg_ok, arm_ok;
   logic len_done, gap_done, last_pulse;
   logic tmo_hit;

   assign idle_rdy = (state == IDLE) || (state == READY);
   assign xfer_st  = (state == XFER_REQ) || (state == XFER_REL);

   assign cfg_ok = cfg_wr && idle_rdy;
   // cfg_wr and abort both take precedence over a same-cycle arm
   assign arm_ok = arm && (state == READY) && !cfg_wr && !abort
                   && !pending && (sh_len != '0);

   // period is stretched so start always has >= 2 low cycles
   assign len_x      = {1'b0, sh_len};
   assign per_x      = {1'b0, sh_period};
   assign eff_period = (per_x > len_x + TWO) ? per_x : len_x + TWO;

   assign len_done   = (ph_cnt == len_x - ONE);
   assign gap_done   = (ph_cnt == eff_period - ONE);
   assign last_pulse = (sh_np != '0) && (pulse_cnt == sh_np);

   assign start = (state == PULSE);
   assign busy  = xfer_st || (state == PULSE) || (state == GAP);

   assign dds.REQ            = (state == XFER_REQ);
   assign dds.DDS_freq       = dds_freq_q;
   assign dds.DDS_delta_freq = dds_dfreq_q;
   assign dds.DDS_delta_rate = dds_rate_q;

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE, READY: begin
            // a stale ACK holds off the request until it clears
            if (pending && !dds.ACK) state_nx = XFER_REQ;
            else if (arm_ok)         state_nx = PULSE;
         end
         XFER_REQ: begin
            if (tmo_hit)      state_nx = IDLE;
            else if (dds.ACK) state_nx = XFER_REL;
         end
         XFER_REL: begin
            if (tmo_hit)       state_nx = IDLE;
            else if (!dds.ACK) state_nx = READY;
         end
         PULSE: begin
            if (abort)         state_nx = READY;
            else if (len_done) state_nx = GAP;
         end
         GAP: begin
            if (abort)         state_nx = READY;
            else if (gap_done) state_nx = last_pulse ? READY : PULSE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_48) begin
      if (rst) begin
         state       <= IDLE;
         pending     <= 1'b0;
         sh_freq     <= '0;
         sh_dfreq    <= '0;
         sh_rate     <= '0;
         sh_len      <= '0;
         sh_period   <= '0;
         sh_np       <= '0;
         dds_freq_q  <= '0;
         dds_dfreq_q <= '0;
         dds_rate_q  <= '0;
         ph_cnt      <= '0;
         pulse_cnt   <= '0;
         cfg_valid   <= 1'b0;
         cfg_err     <= 1'b0;
      end else begin
         state   <= state_nx;
         cfg_err <= (cfg_wr && !idle_rdy) || (arm && !arm_ok);

         if (cfg_ok) begin
            sh_freq   <= cfg_freq;
            sh_dfreq  <= cfg_delta_freq;
            sh_rate   <= cfg_delta_rate;
            sh_len    <= cfg_pulse_len;
            sh_period <= cfg_period;
            sh_np     <= cfg_num_pulses;
            pending   <= 1'b1;
         end else if (xfer_st && (state_nx == READY || state_nx == IDLE)) begin
            pending <= 1'b0;
         end

         // words only move while the bus is quiet
         if (idle_rdy && !dds.ACK) begin
            dds_freq_q  <= sh_freq;
            dds_dfreq_q <= sh_dfreq;
            dds_rate_q  <= sh_rate;
         end

         if (state == XFER_REL && state_nx == READY)
            cfg_valid <= 1'b1;

         if (state_nx == PULSE && state != PULSE)
            ph_cnt <= '0;
         else if (state == PULSE || state == GAP)
            ph_cnt <= ph_cnt + ONE;

         if (arm_ok)
            pulse_cnt <= NP_W'(1);
         else if (state == GAP && state_nx == PULSE)
            pulse_cnt <= pulse_cnt + NP_W'(1);
      end
   end

`ifdef CHIRP_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TMO_CYC + 1);

   logic [TW-1:0] tmo_cnt;

   assign tmo_hit = xfer_st && (tmo_cnt == TW'(TMO_CYC - 1));

   always_ff @(posedge clk_48) begin
      if (rst) begin
         tmo_cnt <= '0;
         tmo_err <= 1'b0;
      end else begin
         if (state_nx != state) tmo_cnt <= '0;
         else if (xfer_st)      tmo_cnt <= tmo_cnt + TW'(1);
         if (tmo_hit) tmo_err <= 1'b1;
      end
   end
`else
   assign tmo_hit = 1'b0;
   assign tmo_err = 1'b0;
`endif

endmodule

// File: doc/chirp_seq_ctrl.md
Name: chirp_seq_ctrl

Overview:
- Upstream sequencer for the 96 MHz chirp DDS stage, running in the 48 MHz domain.
- Accepts a chirp configuration (start frequency word, frequency step, step rate, pulse length, repetition period, pulse count).
- Pushes the DDS words across the 48→96 MHz boundary with a 4-phase REQ/ACK handshake.
- Generates the `start` pulse train that gates the DDS.

Parameters:
- CNT_W, 32, width of pulse_len/period counters
- NP_W, 16, width of pulse count
- TMO_CYC, 1024, ACK watchdog limit in clk_48 cycles (used only with the optional feature)

Ports:
- clk_48 in 1 system clock, 48 MHz
- rst in 1 synchronous active-high reset
- cfg_wr in 1 one-cycle strobe: capture cfg_* and transfer
- cfg_freq in 48 start phase increment
- cfg_delta_freq in 48 phase increment step
- cfg_delta_rate in 32 step timer (96 MHz cycles)
- cfg_pulse_len in CNT_W start-high length, clk_48 cycles
- cfg_period in CNT_W pulse repetition period, clk_48 cycles
- cfg_num_pulses in NP_W pulses per burst, 0 = continuous
- arm in 1 one-cycle strobe: begin burst
- abort in 1 one-cycle strobe: stop burst
- ACK in 1 handshake ack from DDS stage (already synchronised to clk_48)
- REQ out 1 handshake request
- DDS_freq out 48 held start word
- DDS_delta_freq out 48 held step word
- DDS_delta_rate out 32 held rate word
- start out 1 DDS run gate
- busy out 1 FSM not in IDLE/READY
- cfg_valid out 1 a transfer has completed since reset
- cfg_err out 1 one-cycle pulse: cfg_wr/arm rejected
- pulse_cnt out NP_W pulses issued in current burst
- tmo_err out 1 sticky ACK timeout (optional feature)

Behaviour:
- Reset values:
  - REQ=0, start=0, busy=0, cfg_valid=0, cfg_err=0, pulse_cnt=0, tmo_err=0
  - DDS_* = 0; FSM=IDLE; pending=0
- States: IDLE, XFER_REQ, XFER_REL, READY, PULSE, GAP.
- cfg_wr in IDLE or READY:
  - Shadow registers capture all cfg_* on the same edge.
  - DDS_* outputs update from the shadow registers next cycle.
  - pending=1.
- cfg_wr in any other state: ignored, cfg_err pulses 1 cycle later.
- IDLE/READY with pending=1 and ACK=0 → XFER_REQ next cycle, REQ=1.
  - If ACK=1 (stale after reset), wait in place until ACK=0.
- XFER_REQ: REQ=1; on ACK=1 → XFER_REL, REQ=0.
- XFER_REL: REQ=0; DDS_* held stable; on ACK=0 → READY, cfg_valid=1, pending=0.
- DDS_* change only in IDLE/READY. They never change while REQ=1 or ACK=1.
- arm in READY:
  - If cfg_pulse_len=0: rejected, cfg_err, stay READY.
  - Otherwise → PULSE next cycle, start=1, pulse_cnt=1, period counter cleared.
- arm in any other state: ignored, cfg_err.
- PULSE: start=1 for exactly cfg_pulse_len cycles, then → GAP, start=0.
- GAP: start=0 until (cycles since pulse rise) = eff_period. eff_period = max(cfg_period, cfg_pulse_len+2), which guarantees ≥2 low cycles so the DDS edge detector re-fires.
- End of GAP:
  - If num_pulses≠0 and pulse_cnt==num_pulses → READY.
  - Otherwise → PULSE, pulse_cnt+1. pulse_cnt wraps modulo 2^NP_W in continuous mode.
- abort in PULSE/GAP: start=0 next cycle, → READY, pulse_cnt holds its value. abort elsewhere: no effect.
- abort and arm in the same cycle: abort wins.
- cfg_wr and arm in the same cycle in READY: cfg_wr wins, arm gets cfg_err.
- busy=1 in XFER_REQ, XFER_REL, PULSE, GAP.
- Reset mid-handshake: REQ drops next edge. The pending transfer is lost; host must re-issue cfg_wr.

Optional Feature:
- Macro CHIRP_SEQ_TIMEOUT_EN.
- Defined:
  - A counter runs in XFER_REQ and XFER_REL and clears on each state entry.
  - Reaching TMO_CYC → IDLE, REQ=0, pending=0, tmo_err=1 (sticky until rst).
- Undefined: no counter; FSM waits indefinitely; tmo_err tied 0.

Test Plan:
- Config transfer: cfg_wr with freq=48'h0000_1000_0000, delta=48'h10, rate=95; ACK model responds after 4 cycles and releases 4 cycles after REQ falls → REQ high until ACK=1, DDS_* stable throughout, cfg_valid=1 after ACK falls, state READY.
- Burst: pulse_len=10, period=25, num_pulses=3, arm → start high 10 cycles at offsets 1, 26, 51; pulse_cnt 1,2,3; READY after cycle 75; busy low.
- Clamp: pulse_len=10, period=5 → eff_period=12, start low exactly 2 cycles between pulses.
- Abort/reject: abort at 4th cycle of pulse 2 → start=0 next cycle, READY, pulse_cnt=2. cfg_wr during GAP → cfg_err 1-cycle pulse, DDS_* unchanged.
- Stale ACK: assert rst with ACK=1 held, then cfg_wr → REQ stays 0 until ACK falls, then handshake completes normally.
- With CHIRP_SEQ_TIMEOUT_EN, TMO_CYC=16, ACK never asserted → REQ drops after 16 cycles, tmo_err=1, IDLE.
